// File: rtl/noc_codec_pkg.sv
// Shared codec definitions: codeword layout, FIFO entry type and the Hamming(7,4) decoder.
// Used by hamming_rx_decoder and any other stage that handles these 11-bit codewords.
package noc_codec_pkg;

  localparam int CW_W = 11;
  localparam int PL_W = 8;

  // Codeword bit index of each Hamming(7,4) position 1..7.
  localparam int P1_POS = 4;
  localparam int P2_POS = 5;
  localparam int D4_POS = 6;
  localparam int P4_POS = 7;
  localparam int D5_POS = 8;
  localparam int D6_POS = 9;
  localparam int D7_POS = 10;

  typedef struct packed {
    logic [PL_W-1:0] data;
    logic            src;
    logic            corr;
  } rx_entry_t;

  typedef struct packed {
    logic            corr;
    logic [PL_W-1:0] data;
  } decode_t;

  function automatic decode_t hamming_decode(input logic [CW_W-1:0] cw);
    logic [2:0]      syn;
    logic [CW_W-1:0] fixed;
    decode_t         res;
    syn[0] = cw[P1_POS] ^ cw[D4_POS] ^ cw[D5_POS] ^ cw[D7_POS];
    syn[1] = cw[P2_POS] ^ cw[D4_POS] ^ cw[D6_POS] ^ cw[D7_POS];
    syn[2] = cw[P4_POS] ^ cw[D5_POS] ^ cw[D6_POS] ^ cw[D7_POS];
    // Position s sits at codeword bit 3+s, i.e. 8 << s; a zero syndrome flips nothing.
    fixed = cw ^ ((syn != 3'd0) ? (CW_W'(8) << syn) : '0);
    res.corr = |syn;
    res.data = {fixed[D7_POS], fixed[D6_POS], fixed[D5_POS], fixed[D4_POS], fixed[3:0]};
    return res;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with valid/ready on both sides, generic over entry type.
// Registered head output, no fall-through: a push is visible only after its edge.
module sync_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  entry_t                   push_data,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output entry_t                   pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  entry_t           mem_q [DEPTH];
  logic             do_push, do_pop;

  assign push_ready = !rst && (count_q < FULL_CNT);
  assign pop_valid  = !rst && (count_q != '0);
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop_valid && pop_ready;

  // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; stale entries are never observable because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = pop_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

endmodule

// File: rtl/hamming_rx_decoder.sv
// Receive-side Hamming(7,4) checker/corrector feeding a small result FIFO.
// Define HAMMING_RX_STATS_EN to add saturating accept/correct/router counters.
module hamming_rx_decoder
  import noc_codec_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CW_W-1:0]          in_data,
  input  logic                     in_ctrl,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [PL_W-1:0]          out_data,
  output logic                     out_src,
  output logic                     out_corr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef HAMMING_RX_STATS_EN
  ,
  output logic [15:0]              stat_total,
  output logic [15:0]              stat_corr,
  output logic [15:0]              stat_src1
`endif
);

  decode_t   dec;
  rx_entry_t wr_entry;
  rx_entry_t rd_entry;

  always_comb begin
    dec      = hamming_decode(in_data);
    wr_entry = '{data: dec.data, src: in_ctrl, corr: dec.corr};
  end

  sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (rx_entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (wr_entry),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (rd_entry),
    .count      (fifo_count)
  );

  assign out_data = rd_entry.data;
  assign out_src  = rd_entry.src;
  assign out_corr = rd_entry.corr;

`ifdef HAMMING_RX_STATS_EN
  logic        accept;
  logic [15:0] stat_total_q, stat_total_d;
  logic [15:0] stat_corr_q,  stat_corr_d;
  logic [15:0] stat_src1_q,  stat_src1_d;

  assign accept = in_valid && in_ready;

  always_comb begin
    stat_total_d = sat_inc16(stat_total_q, accept);
    stat_corr_d  = sat_inc16(stat_corr_q,  accept && dec.corr);
    stat_src1_d  = sat_inc16(stat_src1_q,  accept && in_ctrl);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total_q <= '0;
      stat_corr_q  <= '0;
      stat_src1_q  <= '0;
    end else begin
      stat_total_q <= stat_total_d;
      stat_corr_q  <= stat_corr_d;
      stat_src1_q  <= stat_src1_d;
    end
  end

  assign stat_total = stat_total_q;
  assign stat_corr  = stat_corr_q;
  assign stat_src1  = stat_src1_q;
`endif

endmodule

// File: tb/tb_hamming_rx_decoder.sv
// Self-checking bench for hamming_rx_decoder: directed vectors plus randomized traffic
// against a queue-based model that decodes by summing set positions into a syndrome.
module tb_hamming_rx_decoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic [10:0]      in_data;
  logic             in_ctrl;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out_data;
  logic             out_src;
  logic             out_corr;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] fifo_count;
`ifdef HAMMING_RX_STATS_EN
  logic [15:0]      stat_total, stat_corr, stat_src1;
`endif

  hamming_rx_decoder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_corr   (out_corr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count)
`ifdef HAMMING_RX_STATS_EN
    ,
    .stat_total (stat_total),
    .stat_corr  (stat_corr),
    .stat_src1  (stat_src1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       src;
    logic       corr;
  } m_t;

  m_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int st_total = 0, st_corr = 0, st_src1 = 0;

  function automatic m_t ref_decode(input logic [10:0] cw, input logic ctrl);
    logic [7:0] pos;
    int         syn;
    m_t         r;
    pos = {cw[10:4], 1'b0};
    syn = 0;
    for (int k = 1; k <= 7; k++) if (pos[k]) syn = syn ^ k;
    if (syn != 0) pos[syn] = ~pos[syn];
    r.data = {pos[7], pos[6], pos[5], pos[3], cw[3:0]};
    r.src  = ctrl;
    r.corr = (syn != 0);
    return r;
  endfunction

  function automatic logic [10:0] encode(input logic [7:0] p);
    logic [7:0] pos;
    pos    = '0;
    pos[3] = p[4];
    pos[5] = p[5];
    pos[6] = p[6];
    pos[7] = p[7];
    for (int k = 1; k <= 4; k = k * 2)
      for (int j = 3; j <= 7; j++)
        if (j != 4 && (j & k) != 0) pos[k] = pos[k] ^ pos[j];
    return {pos[7:1], p[3:0]};
  endfunction

  // Advance one clock, updating the model from the inputs currently driven.
  task automatic tick();
    int sz;
    m_t e;
    sz = exp_q.size();
    if (rst) begin
      exp_q.delete();
      st_total = 0; st_corr = 0; st_src1 = 0;
    end else begin
      if (out_ready && sz != 0) void'(exp_q.pop_front());
      if (in_valid && sz < DEPTH) begin
        e = ref_decode(in_data, in_ctrl);
        exp_q.push_back(e);
        if (st_total < 65535) st_total++;
        if (e.corr && st_corr < 65535) st_corr++;
        if (in_ctrl && st_src1 < 65535) st_src1++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_ctrl = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (fifo_count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
      n_cmp++; if ({out_data, out_src, out_corr} !== 10'h0) begin
        n_bad++; $display("FAIL reset_outputs: got %h/%b/%b want 0", out_data, out_src, out_corr); end
    end
    rst = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (fifo_count !== '0) begin n_bad++; $display("FAIL release_count: got %0d want 0", fifo_count); end
  endtask

  typedef struct {
    logic [10:0] cw;
    logic        ctrl;
    logic [7:0]  data;
    logic        corr;
  } vec_t;

  vec_t vecs[4] = '{
    '{cw: 11'h525, ctrl: 1'b0, data: 8'hA5, corr: 1'b0},
    '{cw: 11'h000, ctrl: 1'b0, data: 8'h00, corr: 1'b0},
    '{cw: 11'h425, ctrl: 1'b1, data: 8'hA5, corr: 1'b1},
    '{cw: 11'h505, ctrl: 1'b0, data: 8'hA5, corr: 1'b1}
  };

  task automatic test_directed();
    foreach (vecs[i]) begin
      in_valid = 1'b1; in_data = vecs[i].cw; in_ctrl = vecs[i].ctrl; out_ready = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dir_no_bypass[%0d]: got %b want 0", i, out_valid); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL dir_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== vecs[i].data) begin
        n_bad++; $display("FAIL dir_data[%0d]: got %h want %h", i, out_data, vecs[i].data); end
      n_cmp++; if (out_corr !== vecs[i].corr) begin
        n_bad++; $display("FAIL dir_corr[%0d]: got %b want %b", i, out_corr, vecs[i].corr); end
      n_cmp++; if (out_src !== vecs[i].ctrl) begin
        n_bad++; $display("FAIL dir_src[%0d]: got %b want %b", i, out_src, vecs[i].ctrl); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dir_drained[%0d]: got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_ctrl = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = encode(8'(8'h40 + i));
      tick();
    end
    rst = 1'b1;
    tick();
    n_cmp++; if (fifo_count !== '0) begin n_bad++; $display("FAIL midrst_count: got %0d want 0", fifo_count); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || fifo_count !== '0) begin
      n_bad++; $display("FAIL midrst_after: got valid=%b count=%0d want 0/0", out_valid, fifo_count); end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      in_valid = 1'b1; in_data = 11'($urandom); in_ctrl = 1'($urandom);
      n_cmp++; if (in_ready !== (i < DEPTH)) begin
        n_bad++; $display("FAIL full_in_ready[%0d]: got %b want %b", i, in_ready, (i < DEPTH)); end
      tick();
      n_cmp++; if (fifo_count !== CNT_W'((i + 1 < DEPTH) ? i + 1 : DEPTH)) begin
        n_bad++; $display("FAIL full_count[%0d]: got %0d want %0d", i, fifo_count, (i + 1 < DEPTH) ? i + 1 : DEPTH); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (exp_q.size() != 0) begin
        n_cmp++; if (out_valid !== 1'b1 || {out_data, out_src, out_corr} !== {exp_q[0].data, exp_q[0].src, exp_q[0].corr}) begin
          n_bad++; $display("FAIL full_drain[%0d]: got %b %h/%b/%b want 1 %h/%b/%b", i, out_valid,
                            out_data, out_src, out_corr, exp_q[0].data, exp_q[0].src, exp_q[0].corr); end
      end
      tick();
      if (i == 0) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_reassert: got %b want 1", in_ready); end
      end
    end
    out_ready = 1'b0;
    n_cmp++; if (fifo_count !== '0) begin n_bad++; $display("FAIL full_empty: got %0d want 0", fifo_count); end
  endtask

  task automatic test_concurrent_wrap();
    out_ready = 1'b0; in_ctrl = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = encode(8'(i));
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = encode(8'(i + 2)); in_ctrl = 1'(i);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        n_bad++; $display("FAIL wrap_order[%0d]: got %b/%h want 1/%h", i, out_valid, out_data, 8'(i)); end
      tick();
      n_cmp++; if (fifo_count !== CNT_W'(2)) begin
        n_bad++; $display("FAIL wrap_count[%0d]: got %0d want 2", i, fifo_count); end
    end
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    n_cmp++; if (fifo_count !== '0) begin n_bad++; $display("FAIL wrap_drain: got %0d want 0", fifo_count); end
  endtask

  task automatic test_random();
    logic [10:0] cw;
    for (int n = 0; n < 400; n++) begin
      cw = encode(8'($urandom));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) cw[$urandom_range(0, 10)] ^= 1'b1;
      in_data   = cw;
      in_ctrl   = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      n_cmp++; if (in_ready !== (exp_q.size() < DEPTH)) begin
        n_bad++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", n, in_ready, (exp_q.size() < DEPTH)); end
      n_cmp++; if (fifo_count !== CNT_W'(exp_q.size())) begin
        n_bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, fifo_count, exp_q.size()); end
      n_cmp++; if (out_valid !== (exp_q.size() != 0)) begin
        n_bad++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", n, out_valid, (exp_q.size() != 0)); end
      if (exp_q.size() != 0) begin
        n_cmp++; if ({out_data, out_src, out_corr} !== {exp_q[0].data, exp_q[0].src, exp_q[0].corr}) begin
          n_bad++; $display("FAIL rnd_head[%0d]: got %h/%b/%b want %h/%b/%b", n, out_data, out_src, out_corr,
                            exp_q[0].data, exp_q[0].src, exp_q[0].corr); end
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

`ifdef HAMMING_RX_STATS_EN
  task automatic test_stats();
    logic [10:0] cws[5];
    logic        ctl[5];
    cws = '{11'h525, 11'h000, encode(8'h3C), 11'h425, 11'h505};
    ctl = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    n_cmp++; if ({stat_total, stat_corr, stat_src1} !== 48'h0) begin
      n_bad++; $display("FAIL stats_reset: got %0d/%0d/%0d want 0/0/0", stat_total, stat_corr, stat_src1); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = cws[i]; in_ctrl = ctl[i];
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (stat_total !== 16'd5 || stat_total !== 16'(st_total)) begin
      n_bad++; $display("FAIL stats_total: got %0d want 5 (model %0d)", stat_total, st_total); end
    n_cmp++; if (stat_corr !== 16'd2 || stat_corr !== 16'(st_corr)) begin
      n_bad++; $display("FAIL stats_corr: got %0d want 2 (model %0d)", stat_corr, st_corr); end
    n_cmp++; if (stat_src1 !== 16'd2 || stat_src1 !== 16'(st_src1)) begin
      n_bad++; $display("FAIL stats_src1: got %0d want 2 (model %0d)", stat_src1, st_src1); end
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    n_cmp++; if ({stat_total, stat_corr, stat_src1} !== 48'h0) begin
      n_bad++; $display("FAIL stats_clear: got %0d/%0d/%0d want 0/0/0", stat_total, stat_corr, stat_src1); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_full();
    test_concurrent_wrap();
    test_random();
`ifdef HAMMING_RX_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
